// File: rtl/calc_pkg.sv
// Shared constants and vector types for the calculator input path.
// Button bit positions are fixed by the board pin order.
package calc_pkg;

  localparam int BTN_CENTER = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_DOWN   = 4;

  localparam int NUM_BTN = 5;
  localparam int SW_W    = 16;

  typedef logic [NUM_BTN-1:0] btn_vec_t;
  typedef logic [SW_W-1:0]    sw_vec_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// Pin-side raw inputs and conditioned outputs handed to calc.
// master drives the raw pins; slave is the conditioner itself.
interface btn_conditioner_if;
  import calc_pkg::*;

  btn_vec_t btn_in;
  sw_vec_t  sw_in;
  btn_vec_t btn_level;
  btn_vec_t btn_pulse;
  sw_vec_t  sw_out;

  modport master (
    output btn_in,
    output sw_in,
    input  btn_level,
    input  btn_pulse,
    input  sw_out
  );

  modport slave (
    input  btn_in,
    input  sw_in,
    output btn_level,
    output btn_pulse,
    output sw_out
  );

endinterface

// File: rtl/debounce_cell.sv
// One button: two-flop synchroniser, stability counter, debounced level and
// registered rising-edge pulse. Latency DEBOUNCE_CYCLES+2 edges; no backpressure.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             done;

  assign differ = s ^ level;
  assign done   = differ && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_a <= raw;
      s      <= sync_a;
      // Any return to the current level discards the partial count.
      if (!differ) begin
        cnt <= '0;
      end else if (done) begin
        cnt   <= '0;
        level <= s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      pulse <= done & s;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the five buttons and synchronises the switches feeding calc.
// Buttons settle after DEBOUNCE_CYCLES+2 edges, switches after 2; no backpressure.
module btn_conditioner
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             resetn,
  btn_conditioner_if.slave bus
);

  btn_vec_t level_vec;
  btn_vec_t pulse_vec;
  sw_vec_t  sw_sync;
  sw_vec_t  sw_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk    (clk),
      .resetn (resetn),
      .raw    (bus.btn_in[i]),
      .level  (level_vec[i]),
      .pulse  (pulse_vec[i])
    );
  end

  // Bit skew across switches is tolerable: calc samples them on a button pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_sync <= '0;
      sw_q    <= '0;
    end else begin
      sw_sync <= bus.sw_in;
      sw_q    <= sw_sync;
    end
  end

  assign bus.btn_level = level_vec;
  assign bus.btn_pulse = pulse_vec;
  assign bus.sw_out    = sw_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench: stimulus schedules expected outputs per cycle into a queue,
// and a negedge monitor compares them against the DUT.
module tb_btn_conditioner;
  import calc_pkg::*;

  localparam int DC = 4;
  localparam int K_LVL = 0;
  localparam int K_PLS = 1;
  localparam int K_SW  = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];

  btn_conditioner_if bus ();

  btn_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic push(input int c, input int k, input logic [15:0] v);
    exp_t e;
    int   i;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endtask

  task automatic push_range(input int a, input int b, input int k, input logic [15:0] v);
    for (int c = a; c <= b; c++) push(c, k, v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    string       nm;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      case (e.kind)
        K_LVL:   begin act = {11'b0, bus.btn_level}; nm = "btn_level"; end
        K_PLS:   begin act = {11'b0, bus.btn_pulse}; nm = "btn_pulse"; end
        default: begin act = bus.sw_out;             nm = "sw_out";    end
      endcase
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s stale expectation for cycle %0d seen at cycle %0d", nm, e.cyc, cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, e.val);
      end
    end
  end

  initial begin
    int n;
    int m;
    int p;
    checks = 0;
    errors = 0;
    resetn = 1'b1;
    bus.btn_in = '0;
    bus.sw_in  = '0;

    // Reset held with everything asserted on the pins.
    #2;
    resetn = 1'b0;
    bus.btn_in = 5'h1F;
    bus.sw_in  = 16'hFFFF;
    tick();
    for (int k = 0; k < 3; k++) push_range(cyc, cyc + 2, k, 16'h0);
    wait_ticks(3);

    // Buttons held through reset release act as a fresh press.
    resetn = 1'b1;
    n = cyc;
    push(n + 1, K_SW, 16'h0000);
    push(n + 2, K_SW, 16'hFFFF);
    push(n + 5, K_LVL, 16'h00);
    push(n + 5, K_PLS, 16'h00);
    push(n + 6, K_LVL, 16'h1F);
    push(n + 6, K_PLS, 16'h1F);
    push(n + 7, K_PLS, 16'h00);
    push(n + 7, K_LVL, 16'h1F);
    wait_ticks(8);

    bus.btn_in = '0;
    n = cyc;
    push(n + 5, K_LVL, 16'h1F);
    push(n + 6, K_LVL, 16'h00);
    push(n + 6, K_PLS, 16'h00);
    wait_ticks(8);

    // Clean press on up.
    bus.btn_in = 5'b00100;
    n = cyc;
    push(n + 5, K_LVL, 16'h00);
    push(n + 6, K_LVL, 16'h04);
    push(n + 6, K_PLS, 16'h04);
    push(n + 7, K_PLS, 16'h00);
    push(n + 10, K_LVL, 16'h04);
    wait_ticks(10);
    bus.btn_in = '0;
    n = cyc;
    push(n + 6, K_LVL, 16'h00);
    push_range(n + 1, n + 7, K_PLS, 16'h00);
    wait_ticks(8);

    // Bouncing center: only the final stable rise counts.
    n = cyc;
    push_range(n + 1, n + 13, K_LVL, 16'h00);
    push_range(n + 1, n + 13, K_PLS, 16'h00);
    push(n + 14, K_LVL, 16'h01);
    push(n + 14, K_PLS, 16'h01);
    push(n + 15, K_PLS, 16'h00);
    bus.btn_in = 5'b00001; wait_ticks(2);
    bus.btn_in = 5'b00000; wait_ticks(2);
    bus.btn_in = 5'b00001; wait_ticks(2);
    bus.btn_in = 5'b00000; wait_ticks(2);
    bus.btn_in = 5'b00001; wait_ticks(8);
    bus.btn_in = '0;
    n = cyc;
    push(n + 6, K_LVL, 16'h00);
    wait_ticks(8);

    // Release on down gives no pulse.
    bus.btn_in = 5'b10000;
    n = cyc;
    push(n + 6, K_LVL, 16'h10);
    push(n + 6, K_PLS, 16'h10);
    push(n + 7, K_PLS, 16'h00);
    wait_ticks(8);
    bus.btn_in = '0;
    m = cyc;
    push(m + 5, K_LVL, 16'h10);
    push(m + 6, K_LVL, 16'h00);
    push_range(m + 1, m + 8, K_PLS, 16'h00);
    wait_ticks(9);

    // Simultaneous press on center, left and right.
    bus.btn_in = 5'b01011;
    n = cyc;
    push(n + 5, K_PLS, 16'h00);
    push(n + 6, K_PLS, 16'h0B);
    push(n + 6, K_LVL, 16'h0B);
    push(n + 7, K_PLS, 16'h00);
    wait_ticks(8);
    bus.btn_in = '0;
    n = cyc;
    push(n + 6, K_LVL, 16'h00);
    wait_ticks(8);

    // Switches follow after two edges.
    bus.sw_in = 16'h354A;
    n = cyc;
    push(n + 1, K_SW, 16'hFFFF);
    push(n + 2, K_SW, 16'h354A);
    wait_ticks(2);
    bus.sw_in = 16'h1234;
    n = cyc;
    push(n + 1, K_SW, 16'h354A);
    push(n + 2, K_SW, 16'h1234);
    wait_ticks(4);

    // Reset in the middle of a left press discards the count.
    bus.btn_in = 5'b00010;
    n = cyc;
    push_range(n + 1, n + 2, K_PLS, 16'h00);
    wait_ticks(2);
    resetn = 1'b0;
    push(cyc, K_LVL, 16'h00);
    push(cyc, K_PLS, 16'h00);
    push(cyc, K_SW, 16'h0000);
    wait_ticks(2);
    resetn = 1'b1;
    p = cyc;
    push(p + 1, K_SW, 16'h0000);
    push(p + 2, K_SW, 16'h1234);
    push_range(p + 1, p + 5, K_PLS, 16'h00);
    push(p + 5, K_LVL, 16'h00);
    push(p + 6, K_LVL, 16'h02);
    push(p + 6, K_PLS, 16'h02);
    push(p + 7, K_PLS, 16'h00);
    wait_ticks(10);

    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
